reg13_serial_reader: RTL and testbench

- Reads a 13-bit register value on request and transmits it bit-serially: start bit, 13 data bits MSB first, optional even-parity bit, stop bit.
- Read/transmit end for the 13-bit holding registers. Used to export register contents (PC, address latches) over a single debug wire.
- Completion handshake back to the requesting controller.

---
 rtl/reg13_serial_reader.sv | 160 ++++++++++++++++
 tb/tb_reg13_serial_reader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg13_serial_reader.sv
// ---------------------------------------------------------------------------
// reg13_serial_reader
//
// Captures a register value on request and shifts it out on a single debug
// wire: start bit (0), WIDTH data bits MSB first, an optional even-parity
// bit, and a stop bit (1). Every serial bit is held for CLKS_PER_BIT clocks.
//
// Handshake: start is a request level from the controller. The request is
// taken in exactly the cycle where start && readStrobe; readStrobe is high
// only while idle, so a request made while busy is dropped, never queued.
// The controller learns of completion from the one-cycle done pulse.
//
// Ports:
//   clk         system clock, rising-edge active
//   reset       synchronous active-high reset
//   regData     value of the register being read (sampled once per frame)
//   start       request to read and transmit regData
//   readStrobe  one-cycle pulse in the cycle regData is captured
//   serOut      serial line, idles high
//   busy        a frame is in progress
//   done        one-cycle pulse on the last cycle of the stop bit
// ---------------------------------------------------------------------------
module reg13_serial_reader #(
   parameter int WIDTH        = 13,
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_EN    = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] regData,
   input  logic             start,
   output logic             readStrobe,
   output logic             serOut,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam int             BW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0]  BIT_LAST  = BW'(WIDTH - 1);
   localparam logic [7:0]     TICK_LAST = 8'(CLKS_PER_BIT - 1);

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic             par_bit;
   logic [BW-1:0]    bit_cnt;
   logic [7:0]       tick_cnt;
   logic [7:0]       tick_next;
   logic             last_tick;

   assign tick_next  = tick_cnt + 8'd1;
   assign last_tick  = (tick_cnt == TICK_LAST);

   // Reset takes priority so a simultaneous request is never acknowledged.
   assign readStrobe = (state == S_IDLE) && start && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         shreg    <= '0;
         par_bit  <= 1'b0;
         bit_cnt  <= '0;
         tick_cnt <= '0;
         serOut   <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               serOut <= 1'b1;
               busy   <= 1'b0;
               if (start) begin
                  shreg    <= regData;
                  par_bit  <= ^regData;
                  state    <= S_START;
                  busy     <= 1'b1;
                  serOut   <= 1'b0;
                  tick_cnt <= '0;
               end
            end

            S_START: begin
               if (last_tick) begin
                  state    <= S_DATA;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  serOut   <= shreg[WIDTH-1];
               end else begin
                  tick_cnt <= tick_next;
               end
            end

            S_DATA: begin
               if (last_tick) begin
                  tick_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     if (PARITY_EN) begin
                        state  <= S_PARITY;
                        serOut <= par_bit;
                     end else begin
                        state  <= S_STOP;
                        serOut <= 1'b1;
                        // A one-clock stop bit is its own final cycle.
                        done   <= (CLKS_PER_BIT == 1);
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= {shreg[WIDTH-2:0], 1'b0};
                     // Register the next MSB now so the line changes on the
                     // same edge as the shift.
                     serOut  <= shreg[WIDTH-2];
                  end
               end else begin
                  tick_cnt <= tick_next;
               end
            end

            S_PARITY: begin
               if (last_tick) begin
                  state    <= S_STOP;
                  tick_cnt <= '0;
                  serOut   <= 1'b1;
                  done     <= (CLKS_PER_BIT == 1);
               end else begin
                  tick_cnt <= tick_next;
               end
            end

            S_STOP: begin
               if (last_tick) begin
                  state    <= S_IDLE;
                  tick_cnt <= '0;
                  busy     <= 1'b0;
                  serOut   <= 1'b1;
               end else begin
                  tick_cnt <= tick_next;
                  // done is registered, so raise it one edge ahead of the
                  // final stop cycle.
                  done     <= (tick_next == TICK_LAST);
               end
            end

            default: begin
               state  <= S_IDLE;
               serOut <= 1'b1;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg13_serial_reader.sv
// ---------------------------------------------------------------------------
// tb_reg13_serial_reader
//
// Directed bench for reg13_serial_reader. dut1 uses the default parameters
// (13 bits, 4 clocks per bit, parity on); dut2 uses parity off and one clock
// per bit. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge. Cycle 1 is the first START cycle of a frame.
// ---------------------------------------------------------------------------
module tb_reg13_serial_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic [12:0] regData, regData2;
   logic        start, start2;
   logic        readStrobe, serOut, busy, done;
   logic        readStrobe2, serOut2, busy2, done2;

   int vectors     = 0;
   int miscompares = 0;

   // Per-cycle samples taken by capture(); index 0 is the first falling edge
   // after the call.
   logic obs_ser[0:79], obs_busy[0:79], obs_done[0:79], obs_rs[0:79];
   logic obs_ser2[0:79], obs_busy2[0:79], obs_done2[0:79], obs_rs2[0:79];

   reg13_serial_reader dut1 (
      .clk        (clk),
      .reset      (reset),
      .regData    (regData),
      .start      (start),
      .readStrobe (readStrobe),
      .serOut     (serOut),
      .busy       (busy),
      .done       (done)
   );

   reg13_serial_reader #(.WIDTH(13), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)) dut2 (
      .clk        (clk),
      .reset      (reset),
      .regData    (regData2),
      .start      (start2),
      .readStrobe (readStrobe2),
      .serOut     (serOut2),
      .busy       (busy2),
      .done       (done2)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- drivers ----------------
   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         obs_ser[i]   = serOut;
         obs_busy[i]  = busy;
         obs_done[i]  = done;
         obs_rs[i]    = readStrobe;
         obs_ser2[i]  = serOut2;
         obs_busy2[i] = busy2;
         obs_done2[i] = done2;
         obs_rs2[i]   = readStrobe2;
      end
   endtask

   // Raise start for one cycle on dut1; returns 1 time unit into cycle 1.
   task automatic request1(input logic [12:0] value, output logic rs_seen);
      @(posedge clk); #1;
      regData = value;
      start   = 1'b1;
      @(negedge clk);
      rs_seen = readStrobe;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; start = 1'b0; start2 = 1'b0;
      regData = '0; regData2 = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      capture(10);
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if ({obs_ser[i], obs_busy[i], obs_done[i], obs_rs[i]} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_idle c=%0d: got ser/busy/done/rs=%b%b%b%b, want 1000",
                     i, obs_ser[i], obs_busy[i], obs_done[i], obs_rs[i]);
         end
         vectors++;
         if ({obs_ser2[i], obs_busy2[i], obs_done2[i], obs_rs2[i]} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_idle2 c=%0d: got ser/busy/done/rs=%b%b%b%b, want 1000",
                     i, obs_ser2[i], obs_busy2[i], obs_done2[i], obs_rs2[i]);
         end
      end
   endtask

   task automatic test_single_frame();
      // 13'h1A5C = 1101001011100 (seven 1s, so parity 1)
      logic [15:0] exp_frame;
      logic        rs;
      exp_frame = {1'b0, 13'h1A5C, 1'b1, 1'b1};
      request1(13'h1A5C, rs);
      vectors++;
      if (rs !== 1'b1) begin
         miscompares++;
         $display("FAIL single_strobe: got readStrobe=%b, want 1", rs);
      end
      capture(65);
      for (int c = 0; c < 64; c++) begin
         vectors++;
         if (obs_ser[c] !== exp_frame[15 - c/4]) begin
            miscompares++;
            $display("FAIL single_ser cycle=%0d: got %b, want %b", c + 1, obs_ser[c], exp_frame[15 - c/4]);
         end
         vectors++;
         if (obs_done[c] !== (c == 63) || obs_busy[c] !== 1'b1 || obs_rs[c] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ctl cycle=%0d: got done/busy/rs=%b%b%b, want %b10",
                     c + 1, obs_done[c], obs_busy[c], obs_rs[c], (c == 63));
         end
      end
      vectors++;
      if (obs_busy[64] !== 1'b0 || obs_ser[64] !== 1'b1 || obs_done[64] !== 1'b0) begin
         miscompares++;
         $display("FAIL single_end cycle=65: got busy/ser/done=%b%b%b, want 010",
                  obs_busy[64], obs_ser[64], obs_done[64]);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_a, exp_b;
      logic        rs;
      int          done_pulses;
      exp_a = {1'b0, 13'h0000, 1'b0, 1'b1};
      exp_b = {1'b0, 13'h1FFF, 1'b1, 1'b1};
      done_pulses = 0;
      request1(13'h0000, rs);
      capture(64);
      for (int c = 0; c < 64; c++) begin
         if (obs_done[c] === 1'b1) done_pulses++;
         vectors++;
         if (obs_ser[c] !== exp_a[15 - c/4] || obs_done[c] !== (c == 63)) begin
            miscompares++;
            $display("FAIL b2b_a cycle=%0d: got ser/done=%b%b, want %b%b",
                     c + 1, obs_ser[c], obs_done[c], exp_a[15 - c/4], (c == 63));
         end
      end
      // First idle cycle after done: new request accepted here.
      @(posedge clk); #1;
      regData = 13'h1FFF;
      start   = 1'b1;
      @(negedge clk);
      vectors++;
      if ({serOut, busy, readStrobe} !== 3'b101) begin
         miscompares++;
         $display("FAIL b2b_gap: got ser/busy/rs=%b%b%b, want 101", serOut, busy, readStrobe);
      end
      @(posedge clk); #1;
      start = 1'b0;
      capture(65);
      for (int c = 0; c < 64; c++) begin
         if (obs_done[c] === 1'b1) done_pulses++;
         vectors++;
         if (obs_ser[c] !== exp_b[15 - c/4] || obs_done[c] !== (c == 63)) begin
            miscompares++;
            $display("FAIL b2b_b cycle=%0d: got ser/done=%b%b, want %b%b",
                     c + 1, obs_ser[c], obs_done[c], exp_b[15 - c/4], (c == 63));
         end
      end
      vectors++;
      if (done_pulses != 2) begin
         miscompares++;
         $display("FAIL b2b_done_count: got %0d, want 2", done_pulses);
      end
   endtask

   task automatic test_no_parity_fast();
      logic [14:0] exp_frame;
      exp_frame = {1'b0, 13'h0001, 1'b1};
      @(posedge clk); #1;
      regData2 = 13'h0001;
      start2   = 1'b1;
      @(negedge clk);
      vectors++;
      if (readStrobe2 !== 1'b1) begin
         miscompares++;
         $display("FAIL np_strobe: got %b, want 1", readStrobe2);
      end
      @(posedge clk); #1;
      start2 = 1'b0;
      capture(16);
      for (int c = 0; c < 15; c++) begin
         vectors++;
         if (obs_ser2[c] !== exp_frame[14 - c] || obs_done2[c] !== (c == 14) || obs_busy2[c] !== 1'b1) begin
            miscompares++;
            $display("FAIL np_frame cycle=%0d: got ser/done/busy=%b%b%b, want %b%b1",
                     c + 1, obs_ser2[c], obs_done2[c], obs_busy2[c], exp_frame[14 - c], (c == 14));
         end
      end
      vectors++;
      if (obs_busy2[15] !== 1'b0 || obs_ser2[15] !== 1'b1) begin
         miscompares++;
         $display("FAIL np_end: got busy/ser=%b%b, want 01", obs_busy2[15], obs_ser2[15]);
      end
   endtask

   task automatic test_ignore_during_frame();
      logic [15:0] exp_frame;
      logic        rs;
      int          strobes;
      exp_frame = {1'b0, 13'h1A5C, 1'b1, 1'b1};
      request1(13'h1A5C, rs);
      fork
         capture(70);
         begin
            repeat (9) @(posedge clk);
            #1 regData = 13'h0FFF; start = 1'b1;   // cycle 10
            @(posedge clk); #1 start = 1'b0;       // cycle 11
            @(posedge clk); #1 start = 1'b1;       // cycle 12
            @(posedge clk); #1 start = 1'b0;       // cycle 13
            repeat (50) @(posedge clk);
            #1 start = 1'b1;                       // cycles 63, 64 (incl. done)
            @(posedge clk);
            @(posedge clk); #1 start = 1'b0;       // cycle 65
         end
      join
      strobes = 0;
      for (int c = 0; c < 64; c++) begin
         if (obs_rs[c] === 1'b1) strobes++;
         vectors++;
         if (obs_ser[c] !== exp_frame[15 - c/4]) begin
            miscompares++;
            $display("FAIL ignore_ser cycle=%0d: got %b, want %b", c + 1, obs_ser[c], exp_frame[15 - c/4]);
         end
      end
      vectors++;
      if (strobes != 0) begin
         miscompares++;
         $display("FAIL ignore_strobe: got %0d extra strobes, want 0", strobes);
      end
      for (int c = 64; c < 70; c++) begin
         vectors++;
         if (obs_busy[c] !== 1'b0 || obs_ser[c] !== 1'b1 || obs_done[c] !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_no_second cycle=%0d: got busy/ser/done=%b%b%b, want 010",
                     c + 1, obs_busy[c], obs_ser[c], obs_done[c]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] exp_frame;
      logic        rs;
      request1(13'h1A5C, rs);
      repeat (29) @(posedge clk);
      #1 reset = 1'b1;                             // cycle 30, DATA bit 6
      @(posedge clk); #1 reset = 1'b0;
      capture(6);
      for (int c = 0; c < 6; c++) begin
         vectors++;
         if ({obs_ser[c], obs_busy[c], obs_done[c]} !== 3'b100) begin
            miscompares++;
            $display("FAIL midreset_idle c=%0d: got ser/busy/done=%b%b%b, want 100",
                     c, obs_ser[c], obs_busy[c], obs_done[c]);
         end
      end
      // 13'h0ABC = 0101010111100 (seven 1s, parity 1)
      exp_frame = {1'b0, 13'h0ABC, 1'b1, 1'b1};
      request1(13'h0ABC, rs);
      vectors++;
      if (rs !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_strobe: got %b, want 1", rs);
      end
      capture(65);
      for (int c = 0; c < 64; c++) begin
         vectors++;
         if (obs_ser[c] !== exp_frame[15 - c/4] || obs_done[c] !== (c == 63)) begin
            miscompares++;
            $display("FAIL midreset_frame cycle=%0d: got ser/done=%b%b, want %b%b",
                     c + 1, obs_ser[c], obs_done[c], exp_frame[15 - c/4], (c == 63));
         end
      end
      vectors++;
      if (obs_busy[64] !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_end: got busy=%b, want 0", obs_busy[64]);
      end
   endtask

   task automatic test_reset_with_start();
      @(posedge clk); #1;
      reset = 1'b1; start = 1'b1; regData = 13'h1FFF;
      @(negedge clk);
      vectors++;
      if (readStrobe !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_start_strobe: got %b, want 0", readStrobe);
      end
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      vectors++;
      if ({serOut, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL rst_start_idle: got ser/busy=%b%b, want 10", serOut, busy);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_no_parity_fast();
      test_ignore_during_frame();
      test_reset_mid_frame();
      test_reset_with_start();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
